// File: rtl/pipelined_add_sub_if.sv
// Handshake and data bundle for pipelined_add_sub.
// The slave modport is the adder's view. The master modport is the view of
// the producer/consumer that drives it.
interface pipelined_add_sub_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// Carry-chain adder/subtractor, pipelined CHUNK bits per stage.
// Stage k adds slice k using the carry registered by stage k-1.
// Operands and the partial sum ride along, so all slices of one result
// leave the pipeline together. The whole pipeline freezes while the
// output is offered but not taken.
module pipelined_add_sub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_add_sub_if.slave bus
);
    localparam int unsigned STAGES = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
    localparam int unsigned LAST   = STAGES - 1;

    generate
        if (CHUNK < 1) begin : g_bad_chunk
            $error("pipelined_add_sub: CHUNK must be at least 1");
        end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("pipelined_add_sub: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    // Per-stage registers. r_b holds B already conditioned for subtraction.
    logic             r_v   [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic             r_c   [STAGES];
    logic             r_ovf;

    // Stage inputs: the port side for stage 0, the previous stage otherwise.
    logic             w_v_in [STAGES];
    logic [WIDTH-1:0] w_a_in [STAGES];
    logic [WIDTH-1:0] w_b_in [STAGES];
    logic [WIDTH-1:0] w_s_in [STAGES];
    logic             w_c_in [STAGES];

    logic [CHUNK:0]   w_add  [STAGES];
    logic [WIDTH-1:0] w_s_nx [STAGES];
    logic             w_c_nx [STAGES];
    logic             w_ovf_nx;
    logic             w_stall;

    assign w_stall       = r_v[LAST] && !bus.out_ready;
    assign bus.in_ready  = !w_stall;
    assign bus.out_valid = r_v[LAST];
    assign bus.sum       = r_sum[LAST];
    assign bus.cout      = r_c[LAST];
    assign bus.ovf       = r_ovf;

    // Route each stage's inputs. Subtraction becomes A + ~B + 1 at entry.
    always_comb begin
        w_v_in[0] = bus.in_valid;
        w_a_in[0] = bus.a;
        w_b_in[0] = bus.sub ? ~bus.b : bus.b;
        w_s_in[0] = '0;
        w_c_in[0] = bus.sub;
        for (int unsigned k = 1; k < STAGES; k++) begin
            w_v_in[k] = r_v[k-1];
            w_a_in[k] = r_a[k-1];
            w_b_in[k] = r_b[k-1];
            w_s_in[k] = r_sum[k-1];
            w_c_in[k] = r_c[k-1];
        end
    end

    // Slice adders. The carry into the MSB is recovered as a ^ b ^ s at the MSB.
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            w_add[k]  = {1'b0, w_a_in[k][k*CHUNK +: CHUNK]}
                      + {1'b0, w_b_in[k][k*CHUNK +: CHUNK]}
                      + (CHUNK+1)'(w_c_in[k]);
            w_s_nx[k] = w_s_in[k];
            w_s_nx[k][k*CHUNK +: CHUNK] = w_add[k][CHUNK-1:0];
            w_c_nx[k] = w_add[k][CHUNK];
        end
        w_ovf_nx = w_a_in[LAST][WIDTH-1] ^ w_b_in[LAST][WIDTH-1]
                 ^ w_s_nx[LAST][WIDTH-1] ^ w_c_nx[LAST];
    end

    // Advance all stages together unless stalled.
    // Data registers load only behind a valid entry, so results hold across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_v[k]   <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (!w_stall) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_v[k] <= w_v_in[k];
                if (w_v_in[k]) begin
                    r_a[k]   <= w_a_in[k];
                    r_b[k]   <= w_b_in[k];
                    r_sum[k] <= w_s_nx[k];
                    r_c[k]   <= w_c_nx[k];
                end
            end
            if (w_v_in[LAST]) begin
                r_ovf <= w_ovf_nx;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub.
// One DUT uses the 32/8 configuration (four stages) and one uses 16/16 (a single stage).
module tb_pipelined_add_sub;
    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    pipelined_add_sub_if #(.WIDTH(32)) bus32 ();
    pipelined_add_sub_if #(.WIDTH(16)) bus16 ();

    pipelined_add_sub #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32.slave)
    );

    pipelined_add_sub #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus32.a        = a;
        bus32.b        = b;
        bus32.sub      = s;
        bus32.in_valid = 1'b1;
    endtask

    // Issue one op and check the exact 4-cycle latency, the result, and hold afterwards.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] es, input logic ec,
                           input logic eo);
        drive32(a, b, s);
        tick();
        bus32.in_valid = 1'b0;
        tick();
        tick();
        check({tag, ".early"}, bus32.out_valid, 0);
        tick();
        check({tag, ".valid"}, bus32.out_valid, 1);
        check({tag, ".sum"},   bus32.sum, es);
        check({tag, ".cout"},  bus32.cout, ec);
        check({tag, ".ovf"},   bus32.ovf, eo);
        tick();
        check({tag, ".single"}, bus32.out_valid, 0);
        check({tag, ".hold"},   bus32.sum, es);
    endtask

    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic        vs [8];
    logic [31:0] es [8];
    logic        ec [8];
    logic        eo [8];

    initial begin
        int i;
        int r;
        int stall_left;
        int last_cyc;
        logic acc_in;
        logic acc_out;

        va = '{32'h00000001, 32'h000000FF, 32'h0000FFFF, 32'h00FFFFFF,
               32'h0000000A, 32'h00000003, 32'h80000000, 32'h7FFFFFFF};
        vb = '{32'h00000002, 32'h00000001, 32'h00000001, 32'h00000001,
               32'h00000003, 32'h0000000A, 32'h80000000, 32'hFFFFFFFF};
        vs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        es = '{32'h00000003, 32'h00000100, 32'h00010000, 32'h01000000,
               32'h00000007, 32'hFFFFFFF9, 32'h00000000, 32'h80000000};
        ec = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        eo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst_n           = 1'b0;
        bus32.in_valid  = 1'b0;
        bus32.a         = '0;
        bus32.b         = '0;
        bus32.sub       = 1'b0;
        bus32.out_ready = 1'b1;
        bus16.in_valid  = 1'b0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.sub       = 1'b0;
        bus16.out_ready = 1'b1;

        // Reset state, checked before any clock edge.
        #1;
        check("rst.out_valid", bus32.out_valid, 0);
        check("rst.sum",       bus32.sum, 0);
        check("rst.cout",      bus32.cout, 0);
        check("rst.ovf",       bus32.ovf, 0);
        check("rst.in_ready",  bus32.in_ready, 1);
        check("rst16.out_valid", bus16.out_valid, 0);
        check("rst16.in_ready",  bus16.in_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single ops, with carries across every chunk boundary and signed overflow.
        run_one("wrap",    32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run_one("povf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_one("novf",    32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        run_one("borrow",  32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_one("zsub",    32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
        run_one("slices",  32'h12345678, 32'h0F0F0F0F, 1'b0, 32'h21436587, 1'b0, 1'b0);

        // Back-to-back burst; the consumer stalls 3 cycles when the first result appears.
        i = 0;
        r = 0;
        stall_left = 3;
        last_cyc = -1;
        drive32(va[0], vb[0], vs[0]);
        for (int cyc = 0; cyc < 60 && r < 8; cyc++) begin
            if (bus32.out_valid && r == 0 && stall_left > 0) begin
                bus32.out_ready = 1'b0;
                #1;
                check("stall.in_ready", bus32.in_ready, 0);
                check("stall.valid",    bus32.out_valid, 1);
                check("stall.sum",      bus32.sum, es[0]);
                stall_left--;
            end else begin
                bus32.out_ready = 1'b1;
                #1;
            end
            acc_out = bus32.out_valid && bus32.out_ready;
            acc_in  = bus32.in_valid && bus32.in_ready;
            if (acc_out) begin
                check($sformatf("burst%0d.sum", r),  bus32.sum,  es[r]);
                check($sformatf("burst%0d.cout", r), bus32.cout, ec[r]);
                check($sformatf("burst%0d.ovf", r),  bus32.ovf,  eo[r]);
                r++;
                last_cyc = cyc;
            end
            tick();
            if (acc_in) begin
                i++;
                if (i < 8) drive32(va[i], vb[i], vs[i]);
                else bus32.in_valid = 1'b0;
            end
        end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        check("burst.count",    r, 8);
        check("burst.last_cyc", last_cyc, 14);
        tick();
        check("burst.drained", bus32.out_valid, 0);

        // Reset mid-cycle with the first result presented and three more in flight.
        drive32(32'hC0000000, 32'h80000000, 1'b0);
        tick();
        drive32(32'h00000001, 32'h00000001, 1'b0);
        tick();
        drive32(32'h00000002, 32'h00000002, 1'b0);
        tick();
        drive32(32'h00000003, 32'h00000003, 1'b0);
        tick();
        bus32.in_valid = 1'b0;
        check("pre_rst.valid", bus32.out_valid, 1);
        check("pre_rst.sum",   bus32.sum, 32'h40000000);
        check("pre_rst.cout",  bus32.cout, 1);
        check("pre_rst.ovf",   bus32.ovf, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst.valid",    bus32.out_valid, 0);
        check("mid_rst.sum",      bus32.sum, 0);
        check("mid_rst.cout",     bus32.cout, 0);
        check("mid_rst.ovf",      bus32.ovf, 0);
        check("mid_rst.in_ready", bus32.in_ready, 1);
        tick();
        check("in_rst.valid",    bus32.out_valid, 0);
        check("in_rst.in_ready", bus32.in_ready, 1);
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            check($sformatf("post_rst%0d.valid", n), bus32.out_valid, 0);
        end
        run_one("post_rst", 32'h00000001, 32'h00000001, 1'b1, 32'h00000000, 1'b1, 1'b0);

        // Single-stage configuration: 1-cycle latency.
        bus16.a        = 16'hFFFF;
        bus16.b        = 16'hFFFF;
        bus16.sub      = 1'b0;
        bus16.in_valid = 1'b1;
        #1;
        check("w16.early", bus16.out_valid, 0);
        tick();
        bus16.a   = 16'h7FFF;
        bus16.b   = 16'h0001;
        check("w16a.valid", bus16.out_valid, 1);
        check("w16a.sum",   bus16.sum, 16'hFFFE);
        check("w16a.cout",  bus16.cout, 1);
        check("w16a.ovf",   bus16.ovf, 0);
        tick();
        bus16.in_valid = 1'b0;
        check("w16b.valid", bus16.out_valid, 1);
        check("w16b.sum",   bus16.sum, 16'h8000);
        check("w16b.cout",  bus16.cout, 0);
        check("w16b.ovf",   bus16.ovf, 1);
        tick();
        check("w16.bubble", bus16.out_valid, 0);
        check("w16.hold",   bus16.sum, 16'h8000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pipelined_add_sub.md
PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 The module SHALL have parameter CHUNK, default 8, meaning bits added per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 The module SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1, meaning the operand set is presented.
REQ-006 The module SHALL have port in_ready, output, 1, meaning the operand set is accepted this cycle.
REQ-007 The module SHALL have port a, input, WIDTH, meaning operand A.
REQ-008 The module SHALL have port b, input, WIDTH, meaning operand B.
REQ-009 The module SHALL have port sub, input, 1, meaning 0 = A+B, 1 = A-B.
REQ-010 The module SHALL have port out_valid, output, 1, meaning a result is presented.
REQ-011 The module SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-012 The module SHALL have port sum, output, WIDTH, meaning the result.
REQ-013 The module SHALL have port cout, output, 1, meaning carry out of the MSB; for subtraction 1 = no borrow.
REQ-014 The module SHALL have port ovf, output, 1, meaning two's-complement signed overflow.

Function
REQ-015 Elaboration SHALL fail if WIDTH % CHUNK != 0 or CHUNK < 1.
REQ-016 Subtraction SHALL be A + ~B with carry-in 1; addition SHALL use carry-in 0; sub SHALL travel with its operand set.
REQ-017 Stage k (0..STAGES-1) SHALL add bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1; unprocessed operand slices and completed sum slices SHALL be delay-registered so every slice of one result exits together.
REQ-018 Latency SHALL be exactly STAGES cycles from the accept edge (in_valid && in_ready) to out_valid, with no stall.
REQ-019 Throughput SHALL be one operation per cycle when out_ready stays high.
REQ-020 Each stage SHALL hold a valid bit; stall = out_valid && !out_ready; in_ready = !stall.
REQ-021 On stall, all stage registers SHALL hold; no operand SHALL be lost or duplicated; sum/cout/ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 With no stall, a bubble (in_valid=0) SHALL advance as an invalid stage; bubbles SHALL NOT be compressed.
REQ-023 ovf SHALL be the carry into the MSB XOR the carry out of the MSB, computed in the final stage.
REQ-024 Accept and output in the same cycle (no stall) SHALL both complete.
REQ-025 When out_valid=0, sum/cout/ovf SHALL hold their last value; consumers SHALL ignore them.

Reset
REQ-026 rst_n=0 SHALL immediately clear all stage valid bits, out_valid, sum, cout and ovf to 0, regardless of clk.
REQ-027 in_ready SHALL read 1 during and after reset.
REQ-028 Reset mid-operation SHALL discard all in-flight results; the first out_valid after release SHALL belong to an operand accepted after release.
REQ-029 Reset release SHALL be synchronised externally; the block requires none internally.

Verification (WIDTH=32, CHUNK=8, STAGES=4 unless stated)
REQ-030 a=0xFFFFFFFF, b=1, sub=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0, cout=1, ovf=0.
REQ-031 a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, cout=0, ovf=1; a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
REQ-032 a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-033 8 back-to-back random ops, out_ready low for 3 cycles once the first result appears -> in_ready=0 for those 3 cycles, outputs stable, all 8 results in order and matching the reference model.
REQ-034 rst_n pulsed low mid-edge with 3 ops in flight -> out_valid=0 at once, no stale result after release, the next op returns at latency 4.
REQ-035 WIDTH=16, CHUNK=16 -> STAGES=1, latency 1 cycle; a=0xFFFF, b=0xFFFF, sub=0 -> sum=0xFFFE, cout=1, ovf=0.
